// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants and helpers for the data-memory access
// controller (state encodings, default geometry, wait-counter width).
// The optional address check is enabled by MEM_CTRL_RANGE_CHECK_EN.
package mem_ctrl_pkg;

   // FSM state encodings
   localparam logic [1:0] IDLE_S   = 2'd0;
   localparam logic [1:0] ACCESS_S = 2'd1;
   localparam logic [1:0] DONE_S   = 2'd2;

   // Default geometry and timing
   localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
   localparam int          DEF_ADDR_W      = 6;
   localparam int          DEF_WAIT_CYCLES = 3;

   // Wait counter width (covers WAIT_CYCLES up to 15)
   localparam int CNT_W = 4;

   // Operation latched for the access in flight
   typedef struct packed {
      logic is_read;
      logic conflict;
   } op_t;

   // True when addr is word aligned and falls inside the SRAM window.
   // Computed on 33 bits so the upper bound cannot wrap.
   function automatic logic addr_in_window(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int          addr_w);
      logic [32:0] a_v;
      logic [32:0] lo_v;
      logic [32:0] hi_v;
      a_v  = {1'b0, addr};
      lo_v = {1'b0, base};
      hi_v = lo_v + (33'd4 << addr_w);
      return (a_v >= lo_v) && (a_v < hi_v) && (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: MEM-stage request/response signals plus the SRAM bus.
// The controller connects through the slave modport; the environment
// (pipeline stage and SRAM) connects through the master modport.
interface mem_access_ctrl_if
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);
   logic              MEM_R_EN;
   logic              MEM_W_EN;
   logic [31:0]       ALU_Res;
   logic [31:0]       Val_Rm;
   logic              ready;
   logic [31:0]       rdata;
   logic              err;
   logic [ADDR_W-1:0] sram_addr;
   logic [31:0]       sram_wdata;
   logic [31:0]       sram_rdata;
   logic              sram_we_n;
   logic              sram_oe_n;

   modport slave (
      input  MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, sram_rdata,
      output ready, rdata, err, sram_addr, sram_wdata, sram_we_n, sram_oe_n
   );

   modport master (
      output MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, sram_rdata,
      input  ready, rdata, err, sram_addr, sram_wdata, sram_we_n, sram_oe_n
   );
endinterface

// File: rtl/mem_wait_cnt.sv
// mem_wait_cnt: loadable down-counter that paces SRAM wait states.
// Load has priority over enable; the count parks at zero.
module mem_wait_cnt
   import mem_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             zero_o
);
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load, decrement while enabled, otherwise hold.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != {CNT_W{1'b0}})) begin
         cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == {CNT_W{1'b0}});
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle access controller between the MEM stage and
// a single-port word SRAM. Each access holds its strobe for WAIT_CYCLES
// cycles, then spends one DONE cycle with ready high. ready is combinational
// so the freeze starts in the same cycle the request appears.
// Optional feature: define MEM_CTRL_RANGE_CHECK_EN to reject unaligned or
// out-of-window addresses (IDLE -> DONE with err, no strobes).
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          ADDR_W      = DEF_ADDR_W,
   parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
)(
   input  logic             clk,
   input  logic             rst,
   mem_access_ctrl_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   op_t               op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              we_n_q, we_n_d;
   logic              oe_n_q, oe_n_d;
   logic              err_q, err_d;

   logic              req_s;
   logic              reject_s;
   logic [ADDR_W-1:0] req_word_s;
   logic              cnt_load_s;
   logic              cnt_en_s;
   logic              cnt_zero_s;
   logic              ready_s;

   // Decode the request and translate the byte address to an SRAM word.
   always_comb begin
      req_s      = bus.MEM_R_EN | bus.MEM_W_EN;
      req_word_s = ADDR_W'((bus.ALU_Res - BASE_ADDR) >> 2);
`ifdef MEM_CTRL_RANGE_CHECK_EN
      reject_s   = req_s & ~addr_in_window(bus.ALU_Res, BASE_ADDR, ADDR_W);
`else
      reject_s   = 1'b0;
`endif
   end

   // Wait counter is loaded on an accepted request and runs during ACCESS.
   always_comb begin
      cnt_load_s = 1'b0;
      cnt_en_s   = 1'b0;
      if ((state_q == IDLE_S) && req_s && !reject_s) begin
         cnt_load_s = 1'b1;
      end else if (state_q == ACCESS_S) begin
         cnt_en_s = 1'b1;
      end else begin
         cnt_load_s = 1'b0;
         cnt_en_s   = 1'b0;
      end
   end

   mem_wait_cnt u_wait_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load_s),
      .load_val_i (CNT_LOAD),
      .en_i       (cnt_en_s),
      .zero_o     (cnt_zero_s)
   );

   // FSM next state, operand latching, strobe control and load capture.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      we_n_d  = we_n_q;
      oe_n_d  = oe_n_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE_S: begin
            if (req_s && reject_s) begin
               state_d       = DONE_S;
               op_d.is_read  = 1'b0;
               op_d.conflict = 1'b0;
               err_d         = 1'b1;
            end else if (req_s) begin
               // A simultaneous read/write performs only the read.
               state_d       = ACCESS_S;
               op_d.is_read  = bus.MEM_R_EN;
               op_d.conflict = bus.MEM_R_EN & bus.MEM_W_EN;
               addr_d        = req_word_s;
               wdata_d       = bus.Val_Rm;
               oe_n_d        = ~bus.MEM_R_EN;
               we_n_d        = ~(bus.MEM_W_EN & ~bus.MEM_R_EN);
            end else begin
               state_d = IDLE_S;
            end
         end
         ACCESS_S: begin
            if (cnt_zero_s) begin
               state_d = DONE_S;
               we_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               err_d   = op_q.conflict;
               if (op_q.is_read) begin
                  rdata_d = bus.sram_rdata;
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               state_d = ACCESS_S;
            end
         end
         DONE_S: begin
            state_d = IDLE_S;
            we_n_d  = 1'b1;
            oe_n_d  = 1'b1;
         end
         default: begin
            state_d = IDLE_S;
            we_n_d  = 1'b1;
            oe_n_d  = 1'b1;
         end
      endcase
   end

   // Register update with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE_S;
         op_q.is_read  <= 1'b0;
         op_q.conflict <= 1'b0;
         addr_q        <= {ADDR_W{1'b0}};
         wdata_q       <= 32'h0000_0000;
         rdata_q       <= 32'h0000_0000;
         we_n_q        <= 1'b1;
         oe_n_q        <= 1'b1;
         err_q         <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         we_n_q  <= we_n_d;
         oe_n_q  <= oe_n_d;
         err_q   <= err_d;
      end
   end

   // Pipeline may advance in DONE, or in IDLE when nothing is requested.
   always_comb begin
      ready_s = 1'b0;
      if (state_q == DONE_S) begin
         ready_s = 1'b1;
      end else if (state_q == IDLE_S) begin
         ready_s = ~req_s;
      end else begin
         ready_s = 1'b0;
      end
   end

   assign bus.ready      = ready_s;
   assign bus.rdata      = rdata_q;
   assign bus.err        = err_q;
   assign bus.sram_addr  = addr_q;
   assign bus.sram_wdata = wdata_q;
   assign bus.sram_we_n  = we_n_q;
   assign bus.sram_oe_n  = oe_n_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks of mem_access_ctrl
// against a transaction-timeline model and a behavioural SRAM.
module tb_mem_access_ctrl;
   localparam logic [31:0] BASE  = 32'd1024;
   localparam int          AW    = 6;
   localparam int          WC    = 3;
   localparam int          WORDS = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_access_ctrl_if #(.ADDR_W(AW)) bus();

   mem_access_ctrl #(.BASE_ADDR(BASE), .ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Behavioural SRAM: write on a rising edge with we_n low; read when oe_n low.
   logic [31:0] sram_mem [WORDS];
   always @(posedge clk) begin
      if (bus.sram_we_n === 1'b0) sram_mem[bus.sram_addr] <= bus.sram_wdata;
   end
   assign bus.sram_rdata = (bus.sram_oe_n === 1'b0) ? sram_mem[bus.sram_addr] : 32'hA5A5_5A5A;

   int checks = 0;
   int errors = 0;

   // Reference model: one access in flight, tracked by its age in cycles.
   logic [31:0] m_mem [WORDS];
   bit          m_busy, m_read, m_write, m_err, m_clean;
   int          m_age, m_len, m_word;
   logic [31:0] m_data, m_rdata;

   logic          s_ready, s_we_n, s_oe_n, s_err;
   logic [31:0]   s_rdata;
   logic [AW-1:0] s_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit in_window(input logic [31:0] a);
      longint av;
      av = longint'(a);
      return (av >= longint'(BASE)) && (av < longint'(BASE) + 4 * WORDS) && (av % 4 == 0);
   endfunction

   // Compare DUT outputs of the current cycle against the model.
   task automatic check_cycle();
      bit req, e_ready, e_we_n, e_oe_n, e_err, cmp_bus;
      req     = (bus.MEM_R_EN === 1'b1) || (bus.MEM_W_EN === 1'b1);
      e_ready = 1'b1; e_we_n = 1'b1; e_oe_n = 1'b1; e_err = 1'b0;
      cmp_bus = m_clean;
      if (!m_busy) begin
         e_ready = !req;
      end else if (m_age < m_len) begin
         e_ready = 1'b0;
         e_we_n  = !m_write;
         e_oe_n  = !m_read;
         cmp_bus = 1'b1;
      end else begin
         e_err = m_err;
         if (m_read) m_rdata = m_mem[m_word];
      end
      s_ready = bus.ready; s_we_n = bus.sram_we_n; s_oe_n = bus.sram_oe_n;
      s_err = bus.err; s_rdata = bus.rdata; s_addr = bus.sram_addr;
      chk("ready", 32'(s_ready), 32'(e_ready));
      chk("sram_we_n", 32'(s_we_n), 32'(e_we_n));
      chk("sram_oe_n", 32'(s_oe_n), 32'(e_oe_n));
      chk("err", 32'(s_err), 32'(e_err));
      chk("rdata", s_rdata, m_rdata);
      if (cmp_bus) begin
         chk("sram_addr", 32'(s_addr), 32'(m_word));
         chk("sram_wdata", bus.sram_wdata, m_data);
      end
   endtask

   // Advance the model across the coming rising edge.
   task automatic model_edge();
      bit rd, wr, rej;
      rd = (bus.MEM_R_EN === 1'b1);
      wr = (bus.MEM_W_EN === 1'b1);
      if (m_busy && m_write && m_age < m_len) m_mem[m_word] = m_data;
      if (rst !== 1'b1) begin
         m_busy = 1'b0; m_rdata = 32'h0; m_word = 0; m_data = 32'h0; m_clean = 1'b1;
      end else if (!m_busy) begin
         if (rd || wr) begin
            rej = 1'b0;
`ifdef MEM_CTRL_RANGE_CHECK_EN
            rej = !in_window(bus.ALU_Res);
`endif
            m_busy  = 1'b1;
            m_age   = 1;
            m_len   = rej ? 1 : WC + 1;
            m_read  = rd && !rej;
            m_write = wr && !rd && !rej;
            m_err   = (rd && wr) || rej;
            if (!rej) begin
               m_word  = int'(((bus.ALU_Res - BASE) >> 2) % WORDS);
               m_data  = bus.Val_Rm;
               m_clean = 1'b0;
            end
         end
      end else if (m_age == m_len) begin
         m_busy = 1'b0;
      end else begin
         m_age++;
      end
   endtask

   // One clock cycle: check mid-cycle, step the model, return after the edge.
   task automatic step();
      @(negedge clk);
      check_cycle();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   // Issue one access and observe it until DONE (or until reset at rst_at).
   task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input int rst_at,
                            output int n_cyc, output int n_low, output int n_we,
                            output int n_oe, output int n_err,
                            output logic [31:0] rd_done, output logic [AW-1:0] addr_seen);
      bit done;
      done = 1'b0; n_cyc = 0; n_low = 0; n_we = 0; n_oe = 0; n_err = 0;
      rd_done = 32'h0; addr_seen = '0;
      bus.MEM_R_EN = rd; bus.MEM_W_EN = wr; bus.ALU_Res = addr; bus.Val_Rm = data;
      for (int i = 0; (i < 4 * WC + 8) && !done; i++) begin
         if (i == rst_at) rst = 1'b0;
         step();
         n_cyc++;
         if (s_ready !== 1'b1) n_low++;
         if (s_we_n === 1'b0) begin n_we++; addr_seen = s_addr; end
         if (s_oe_n === 1'b0) begin n_oe++; addr_seen = s_addr; end
         if (s_err === 1'b1) n_err++;
         if (i == rst_at) begin
            rst = 1'b1; bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0; done = 1'b1;
         end else if (i > 0 && s_ready === 1'b1) begin
            rd_done = s_rdata; done = 1'b1;
         end
      end
      bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL access_timeout: no DONE within %0d cycles at addr %h", 4 * WC + 8, addr);
      end
   endtask

   initial begin
      int cyc, low, we, oe, er, sel, gap, rat;
      logic [31:0] rdv, addr;
      logic [AW-1:0] ad;
      rst = 1'b0;
      bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0; bus.ALU_Res = 32'h0; bus.Val_Rm = 32'h0;
      for (int i = 0; i < WORDS; i++) begin
         sram_mem[i] = $urandom;
         m_mem[i]    = sram_mem[i];
      end
      m_busy = 1'b0; m_clean = 1'b1; m_rdata = 32'h0; m_word = 0; m_data = 32'h0;
      m_read = 1'b0; m_write = 1'b0; m_err = 1'b0; m_age = 0; m_len = 0;
      repeat (2) @(posedge clk);
      #1;
      step();
      rst = 1'b1;
      chk("reset_ready", 32'(s_ready), 32'd1);
      chk("reset_we_n", 32'(s_we_n), 32'd1);
      chk("reset_oe_n", 32'(s_oe_n), 32'd1);
      chk("reset_rdata", s_rdata, 32'h0);
      chk("reset_addr", 32'(s_addr), 32'd0);

      // Store then load at 1028
      do_access(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, -1, cyc, low, we, oe, er, rdv, ad);
      chk("t1_ready_low", 32'(low), 32'd4);
      chk("t1_we_cycles", 32'(we), 32'd3);
      chk("t1_done_cycle", 32'(cyc), 32'd5);
      chk("t1_addr", 32'(ad), 32'd1);
      do_access(1'b1, 1'b0, 32'd1028, 32'h0, -1, cyc, low, we, oe, er, rdv, ad);
      chk("t2_oe_cycles", 32'(oe), 32'd3);
      chk("t2_rdata_done", rdv, 32'hDEAD_BEEF);
      step(); step();
      chk("t2_rdata_hold", s_rdata, 32'hDEAD_BEEF);

      // Back-to-back stores and loads
      do_access(1'b0, 1'b1, 32'd1024, 32'h1111_1111, -1, cyc, low, we, oe, er, rdv, ad);
      chk("t3_cyc_a", 32'(cyc), 32'd5);
      do_access(1'b0, 1'b1, 32'd1032, 32'h3333_3333, -1, cyc, low, we, oe, er, rdv, ad);
      chk("t3_cyc_b", 32'(cyc), 32'd5);
      chk("t3_addr_b", 32'(ad), 32'd2);
      do_access(1'b1, 1'b0, 32'd1024, 32'h0, -1, cyc, low, we, oe, er, rdv, ad);
      chk("t3_read_a", rdv, 32'h1111_1111);
      do_access(1'b1, 1'b0, 32'd1032, 32'h0, -1, cyc, low, we, oe, er, rdv, ad);
      chk("t3_read_b", rdv, 32'h3333_3333);
      chk("t3_cyc_d", 32'(cyc), 32'd5);

      // Simultaneous read and write
      do_access(1'b1, 1'b1, 32'd1024, 32'h7777_7777, -1, cyc, low, we, oe, er, rdv, ad);
      chk("t5_no_write", 32'(we), 32'd0);
      chk("t5_read", 32'(oe), 32'd3);
      chk("t5_err", 32'(er), 32'd1);
      chk("t5_rdata", rdv, 32'h1111_1111);

`ifdef MEM_CTRL_RANGE_CHECK_EN
      do_access(1'b1, 1'b0, 32'd1020, 32'h0, -1, cyc, low, we, oe, er, rdv, ad);
      chk("t6_low_1020", 32'(low), 32'd1);
      chk("t6_err_1020", 32'(er), 32'd1);
      chk("t6_strobe_1020", 32'(oe + we), 32'd0);
      chk("t6_rdata_1020", rdv, 32'h1111_1111);
      do_access(1'b1, 1'b0, 32'd1282, 32'h0, -1, cyc, low, we, oe, er, rdv, ad);
      chk("t6_low_1282", 32'(low), 32'd1);
      chk("t6_err_1282", 32'(er), 32'd1);
      chk("t6_strobe_1282", 32'(oe + we), 32'd0);
`else
      do_access(1'b1, 1'b0, 32'd1280, 32'h0, -1, cyc, low, we, oe, er, rdv, ad);
      chk("t6_wrap_addr", 32'(ad), 32'd0);
      chk("t6_wrap_rdata", rdv, 32'h1111_1111);
      chk("t6_wrap_err", 32'(er), 32'd0);
`endif

      // Reset during cycle 2 of a store
      do_access(1'b0, 1'b1, 32'd1036, 32'hCAFE_F00D, 2, cyc, low, we, oe, er, rdv, ad);
      chk("t4_ready_low", 32'(low), 32'd3);
      chk("t4_err", 32'(er), 32'd0);
      step();
      chk("t4_idle_ready", 32'(s_ready), 32'd1);
      chk("t4_we_n", 32'(s_we_n), 32'd1);
      chk("t4_rdata", s_rdata, 32'h0);

      // Randomized traffic with occasional mid-access resets
      for (int n = 0; n < 300; n++) begin
         gap = $urandom_range(0, 2);
         repeat (gap) step();
         sel = $urandom_range(0, 7);
         if ($urandom_range(0, 7) == 0) addr = $urandom;
         else addr = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
         rat = ($urandom_range(0, 19) == 0) ? $urandom_range(0, WC + 1) : -1;
         do_access(sel < 4 || sel == 7, sel >= 4, addr, $urandom, rat,
                   cyc, low, we, oe, er, rdv, ad);
      end
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
